// File: rtl/pulse_width_meter_if.sv
// Result/handshake bundle of the pulse width meter: the measured line plus the
// VALID/ACK holding register seen by the downstream consumer.
interface pulse_width_meter_if #(
  parameter int W = 8
);
  logic         SIG;
  logic         ACK;
  logic [W-1:0] WIDTH;
  logic         VALID;
  logic         SAT;
  logic         OVERRUN;

  // Producer/consumer side: drives the pulse and the acknowledge, reads results.
  modport master (
    output SIG,
    output ACK,
    input  WIDTH,
    input  VALID,
    input  SAT,
    input  OVERRUN
  );

  // Meter side.
  modport slave (
    input  SIG,
    input  ACK,
    output WIDTH,
    output VALID,
    output SAT,
    output OVERRUN
  );
endinterface

// File: rtl/pulse_width_meter.sv
// Measures the high time of SIG in CLK cycles and presents it on a VALID/ACK
// holding register; counts saturate at 2**W-1 and flag SAT.
module pulse_width_meter #(
  parameter int W    = 8,
  parameter bit SYNC = 1'b1
) (
  input logic               CLK,
  input logic               N_RESET,
  pulse_width_meter_if.slave bus
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  logic         s;
  logic         rise;
  logic         capture;
  logic         s_prev_q;
  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_int_q, sat_int_d;
  logic [W-1:0] width_q, width_d;
  logic         valid_q, valid_d;
  logic         sat_q, sat_d;
  logic         overrun_q, overrun_d;

  // NOTE: input-history flops reset to 1 so a line already high at reset
  // release looks like "no edge" and is only measured after it falls and rises.
  if (SYNC) begin : g_sync
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
        sync_q <= 2'b11;
      end else begin
        sync_q <= {sync_q[0], bus.SIG};
      end
    end

    assign s = sync_q[1];
  end else begin : g_nosync
    assign s = bus.SIG;
  end

  assign rise = s & ~s_prev_q;

  // Measurement FSM: cnt counts edges that sampled s high, starting at 1 on the rise.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_int_d = sat_int_q;
    capture   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      MEASURE: begin
        if (s) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_q >= CNT_MAX - 1'b1) begin
            sat_int_d = 1'b1;
          end
        end else begin
          capture   = 1'b1;
          cnt_d     = '0;
          sat_int_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a capture always wins over a same-edge ACK.
  always_comb begin
    width_d   = width_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (capture) begin
      width_d   = cnt_q;
      sat_d     = sat_int_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~bus.ACK;
    end else if (valid_q && bus.ACK) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      s_prev_q  <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      sat_int_q <= 1'b0;
      width_q   <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s_prev_q  <= s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sat_int_q <= sat_int_d;
      width_q   <= width_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.WIDTH   = width_q;
  assign bus.VALID   = valid_q;
  assign bus.SAT     = sat_q;
  assign bus.OVERRUN = overrun_q;

endmodule
